vga_sync: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 49 ++++
 rtl/vga_sync.sv | 111 +++++++++++
 tb/tb_vga_sync.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: constants shared by the VGA timing path and the drawing components.
//   - default 640x480@60 timing (visible / front porch / sync / back porch)
//   - derived line and frame totals
//   - 3-bit colour type and the colours the drawing components agree on
package vga_pkg;

  localparam int COUNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [2:0] color_t;

  localparam color_t COLOR_BLACK   = 3'b000;
  localparam color_t COLOR_BG_LINE = 3'b001;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one axis (pixels or lines) of the VGA raster.
//   Counts 0..TOTAL-1, where TOTAL = VISIBLE+FRONT+SYNC+BACK.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         pixel tick; the count only moves when it is high
//   wrap_in        advance request from the faster axis (tie high for the horizontal axis)
//   count          current position
//   wrap_out       this axis is advancing past its last position on this tick
//   sync_active    count lies inside the sync pulse window
//   visible        count lies inside the active area
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               wrap_in,
  output logic [COUNT_W-1:0] count,
  output logic               wrap_out,
  output logic               sync_active,
  output logic               visible
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] VIS_END    = COUNT_W'(VISIBLE);
  localparam logic [COUNT_W-1:0] SYNC_START = COUNT_W'(VISIBLE + FRONT);
  localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(VISIBLE + FRONT + SYNC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable && wrap_in) begin
      count <= (count == LAST) ? '0 : count + COUNT_W'(1);
    end
  end

  // Combinational so the vertical axis sees the wrap in the same tick.
  assign wrap_out    = wrap_in && (count == LAST);
  assign sync_active = (count >= SYNC_START) && (count < SYNC_END);
  assign visible     = (count < VIS_END);

endmodule

// File: rtl/vga_sync.sv
// vga_sync: raster timing generator and pixel output stage.
//   Publishes row/col to the drawing components, samples their rgb_in answer
//   one pixel later and drives the blanked colour plus active-low syncs.
// Ports:
//   clk          system clock (pixel clock, or 2x pixel clock with the divider)
//   reset_n      asynchronous active-low reset
//   rgb_in       colour for the current row/col from the drawing components
//   row, col     current line / pixel counters, straight from the registers
//   hsync, vsync active-low sync pins, registered
//   rgb          blanked colour, registered
//   frame_start  one-clk pulse on the (last,last)->(0,0) wrap
// Build option:
//   VGA_PIXEL_DIV_EN  defined: clk is twice the pixel rate and a phase
//                     register produces a tick on every second clk.
//                     undefined: every clk is a pixel tick.
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               reset_n,
  input  color_t             rgb_in,
  output logic [COUNT_W-1:0] row,
  output logic [COUNT_W-1:0] col,
  output logic               hsync,
  output logic               vsync,
  output color_t             rgb,
  output logic               frame_start
);

  logic pix_en;
  logic h_wrap, h_sync_act, h_vis;
  logic v_wrap, v_sync_act, v_vis;

`ifdef VGA_PIXEL_DIV_EN
  // Phase starts at 0 so the first tick lands on the second clk after release.
  logic phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  assign pix_en = phase;
`else
  assign pix_en = 1'b1;
`endif

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (pix_en),
    .wrap_in     (1'b1),
    .count       (col),
    .wrap_out    (h_wrap),
    .sync_active (h_sync_act),
    .visible     (h_vis)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (pix_en),
    .wrap_in     (h_wrap),
    .count       (row),
    .wrap_out    (v_wrap),
    .sync_active (v_sync_act),
    .visible     (v_vis)
  );

  // Outputs are decoded from the pre-increment counters, so they trail
  // row/col by one tick and stay aligned with each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= COLOR_BLACK;
      frame_start <= 1'b0;
    end else begin
      // Updated every clk so the pulse is one clk wide even with the divider.
      frame_start <= pix_en && v_wrap;
      if (pix_en) begin
        hsync <= ~h_sync_act;
        vsync <= ~v_sync_act;
        rgb   <= (h_vis && v_vis) ? rgb_in : COLOR_BLACK;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
`timescale 1ns/1ps
module tb_vga_sync;
  import vga_pkg::*;

  // Reduced raster for frame-level behaviour (vsync, row wrap, frame_start).
  localparam int SH_V = 16, SH_F = 4, SH_S = 6, SH_B = 4;
  localparam int SV_V = 8,  SV_F = 2, SV_S = 2, SV_B = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  color_t rgb_in_a, rgb_in_b;
  logic [9:0] row_a, col_a, row_b, col_b;
  logic hsync_a, vsync_a, fs_a, hsync_b, vsync_b, fs_b;
  color_t rgb_a, rgb_b;

  always #5 clk = ~clk;

  vga_sync dut_a (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in_a), .row(row_a), .col(col_a),
    .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  vga_sync #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in_b), .row(row_b), .col(col_b),
    .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int ticks = 0;
  int edges = 0;
  bit tick_now = 1'b0;
  color_t tick_rgb_a = '0;
  color_t tick_rgb_b = '0;

  typedef struct {
    color_t     rgb_in;
    logic [9:0] row;
    logic [9:0] col;
    logic       hsync;
    logic       vsync;
    color_t     rgb;
    logic       fs;
  } rst_vec_t;

  rst_vec_t rst_tbl[5];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, ticks);
    end
  endtask

  function automatic bit is_tick(input int e);
`ifdef VGA_PIXEL_DIV_EN
    return (e % 2) == 0;
`else
    return e > 0;
`endif
  endfunction

  // Reference: position after n ticks is plain division of the tick count;
  // registered outputs describe the pixel one tick earlier.
  task automatic check_model(input string tag,
                             input int hv, input int hf, input int hs, input int hb,
                             input int vv, input int vf, input int vs, input int vb,
                             input logic [9:0] row, input logic [9:0] col,
                             input logic hs_o, input logic vs_o, input color_t rgb_o,
                             input logic fs_o, input color_t rgb_at_tick);
    int ht, vt, p, ph, pv;
    logic e_hs, e_vs, e_fs;
    color_t e_rgb;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 3'b000;
    if (ticks > 0) begin
      p  = ticks - 1;
      ph = p % ht;
      pv = (p / ht) % vt;
      e_hs  = !(ph >= hv + hf && ph < hv + hf + hs);
      e_vs  = !(pv >= vv + vf && pv < vv + vf + vs);
      e_rgb = (ph < hv && pv < vv) ? rgb_at_tick : 3'b000;
      e_fs  = tick_now && (ticks % (ht * vt) == 0);
    end
    cmp({tag, ".col"},   32'(col),   32'(ticks % ht));
    cmp({tag, ".row"},   32'(row),   32'((ticks / ht) % vt));
    cmp({tag, ".hsync"}, 32'(hs_o),  32'(e_hs));
    cmp({tag, ".vsync"}, 32'(vs_o),  32'(e_vs));
    cmp({tag, ".rgb"},   32'(rgb_o), 32'(e_rgb));
    cmp({tag, ".frame_start"}, 32'(fs_o), 32'(e_fs));
  endtask

  // mode 0: constant 3'b101, 1: random, 2: background line colour
  task automatic step(input int mode);
    @(posedge clk);
    edges++;
    tick_now = is_tick(edges);
    if (tick_now) begin
      ticks++;
      tick_rgb_a = rgb_in_a;
      tick_rgb_b = rgb_in_b;
    end
    @(negedge clk);
    check_model("A", DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK,
                DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK,
                row_a, col_a, hsync_a, vsync_a, rgb_a, fs_a, tick_rgb_a);
    check_model("B", SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B,
                row_b, col_b, hsync_b, vsync_b, rgb_b, fs_b, tick_rgb_b);
    case (mode)
      0:       begin rgb_in_a = 3'b101; rgb_in_b = 3'b101; end
      2:       begin rgb_in_a = COLOR_BG_LINE; rgb_in_b = COLOR_BG_LINE; end
      default: begin rgb_in_a = color_t'($urandom_range(0, 7)); rgb_in_b = color_t'($urandom_range(0, 7)); end
    endcase
  endtask

  task automatic run_ticks(input int target, input int mode);
    int guard;
    guard = 0;
    while (ticks < target && guard < 20000) begin
      step(mode);
      guard++;
    end
    cmp("run.tick_budget", 32'(ticks), 32'(target));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    edges = 0;
    ticks = 0;
    tick_now = 1'b0;
  endtask

  initial begin
    rgb_in_a = 3'b000;
    rgb_in_b = 3'b000;
    rst_tbl[0] = '{3'b111, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0};
    rst_tbl[1] = '{3'b101, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0};
    rst_tbl[2] = '{3'b010, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0};
    rst_tbl[3] = '{3'b001, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0};
    rst_tbl[4] = '{3'b101, 10'd0, 10'd0, 1'b1, 1'b1, 3'b000, 1'b0};

    // Reset held for five clocks while rgb_in toggles: outputs must stay put.
    foreach (rst_tbl[i]) begin
      @(negedge clk);
      rgb_in_a = rst_tbl[i].rgb_in;
      rgb_in_b = rst_tbl[i].rgb_in;
      @(posedge clk);
      @(negedge clk);
      cmp("rst.row_a",   32'(row_a),   32'(rst_tbl[i].row));
      cmp("rst.col_a",   32'(col_a),   32'(rst_tbl[i].col));
      cmp("rst.hsync_a", 32'(hsync_a), 32'(rst_tbl[i].hsync));
      cmp("rst.vsync_a", 32'(vsync_a), 32'(rst_tbl[i].vsync));
      cmp("rst.rgb_a",   32'(rgb_a),   32'(rst_tbl[i].rgb));
      cmp("rst.fs_a",    32'(fs_a),    32'(rst_tbl[i].fs));
      cmp("rst.row_b",   32'(row_b),   32'(rst_tbl[i].row));
      cmp("rst.hsync_b", 32'(hsync_b), 32'(rst_tbl[i].hsync));
      cmp("rst.rgb_b",   32'(rgb_b),   32'(rst_tbl[i].rgb));
    end

    rgb_in_a = 3'b101;
    rgb_in_b = 3'b101;
    release_reset();
    run_ticks(1000, 0);
    run_ticks(1700, 2);
    run_ticks(2300, 1);

    // Mid-line (row 2, col 700, inside hsync) asynchronous reset.
    cmp("pre_rst.col_a",   32'(col_a),   32'd700);
    cmp("pre_rst.row_a",   32'(row_a),   32'd2);
    cmp("pre_rst.hsync_a", 32'(hsync_a), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("arst.row_a",   32'(row_a),   32'd0);
    cmp("arst.col_a",   32'(col_a),   32'd0);
    cmp("arst.hsync_a", 32'(hsync_a), 32'd1);
    cmp("arst.vsync_a", 32'(vsync_a), 32'd1);
    cmp("arst.rgb_a",   32'(rgb_a),   32'd0);
    cmp("arst.row_b",   32'(row_b),   32'd0);
    cmp("arst.col_b",   32'(col_b),   32'd0);
    cmp("arst.rgb_b",   32'(rgb_b),   32'd0);
    cmp("arst.fs_b",    32'(fs_b),    32'd0);
    @(posedge clk);
    @(negedge clk);
    cmp("arst_hold.col_a", 32'(col_a), 32'd0);

    release_reset();
    run_ticks(1000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
